// File: rtl/seq_cmd_arbiter_pkg.sv
// Shared types and constants for the sequencer command arbiter.
package seq_arb_pkg;

  localparam int unsigned CMD_W  = 2;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP        = 2'b00,
    CMD_RESTART    = 2'b01,
    CMD_PAUSE      = 2'b10,
    CMD_GOTO_THIRD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Level combination presented to the sequencer control inputs
  typedef struct packed {
    logic restart;
    logic pause;
    logic goto_third;
  } ctrl_t;

  // Map a command onto sequencer control levels
  function automatic ctrl_t decode_cmd(input cmd_e cmd);
    ctrl_t c;
    c = '0;
    case (cmd)
      CMD_RESTART:    c.restart = 1'b1;
      CMD_PAUSE:      c.pause   = 1'b1;
      CMD_GOTO_THIRD: begin
        c.restart    = 1'b1;
        c.goto_third = 1'b1;
      end
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_cmd_arbiter_if.sv
// Requester handshake and sequencer control bundle.
// Optional cmd_count member present only with SEQ_ARB_COUNT_EN.
interface seq_cmd_arbiter_if;
  import seq_arb_pkg::*;

  logic                req0;
  logic [CMD_W-1:0]    cmd0;
  logic                ack0;
  logic                req1;
  logic [CMD_W-1:0]    cmd1;
  logic                ack1;
  logic                restart;
  logic                pause;
  logic                goto_third;
  logic                busy;
  logic                grant_id;
`ifdef SEQ_ARB_COUNT_EN
  logic [CNT_W-1:0]    cmd_count;
`endif

  // Arbiter side
  modport slave (
    input  req0, cmd0, req1, cmd1,
    output ack0, ack1, restart, pause, goto_third, busy, grant_id
`ifdef SEQ_ARB_COUNT_EN
    , output cmd_count
`endif
  );

  // Requester / observer side
  modport master (
    output req0, cmd0, req1, cmd1,
    input  ack0, ack1, restart, pause, goto_third, busy, grant_id
`ifdef SEQ_ARB_COUNT_EN
    , input cmd_count
`endif
  );

endinterface

// File: rtl/seq_cmd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant is held by the parent.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/seq_cmd_arbiter.sv
// Command controller driving the three-bit sequencer control lines.
// Two requesters, round-robin arbitration, fixed-length control pulses.
// Optional feature macro: SEQ_ARB_COUNT_EN (adds the cmd_count counter).
module seq_cmd_arbiter
  import seq_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned PAUSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_cmd_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DRIVE = ST_DRIVE;
  localparam logic [1:0] S_ACK   = ST_ACK;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  cmd_e              cmd_q, cmd_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
`ifdef SEQ_ARB_COUNT_EN
  logic [CNT_W-1:0]  cmd_count_q, cmd_count_d;
`endif

  logic arb_valid;
  logic arb_winner;
  cmd_e win_cmd;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Hold length loaded when a command is granted
  function automatic logic [HOLD_W-1:0] hold_load(input cmd_e cmd);
    return (cmd == CMD_PAUSE) ? HOLD_W'(PAUSE_CYCLES) : HOLD_W'(HOLD_CYCLES);
  endfunction

  // Select the winning requester's command
  always_comb begin
    win_cmd = arb_winner ? cmd_e'(bus.cmd1) : cmd_e'(bus.cmd0);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cmd_d        = cmd_q;
    ctrl_d       = '0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
`ifdef SEQ_ARB_COUNT_EN
    cmd_count_d  = cmd_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          cmd_d        = win_cmd;
          grant_id_d   = arb_winner;
          last_grant_d = arb_winner;
          if (win_cmd == CMD_NOP) begin
            state_d = S_ACK;
            ack0_d  = ~arb_winner;
            ack1_d  = arb_winner;
          end else begin
            state_d    = S_DRIVE;
            hold_cnt_d = hold_load(win_cmd);
            ctrl_d     = decode_cmd(win_cmd);
          end
        end
      end

      S_DRIVE: begin
        if (hold_cnt_q <= HOLD_W'(1)) begin
          // Last hold cycle is ending: release the lines and acknowledge
          state_d    = S_ACK;
          hold_cnt_d = '0;
          ack0_d     = ~grant_id_q;
          ack1_d     = grant_id_q;
`ifdef SEQ_ARB_COUNT_EN
          cmd_count_d = cmd_count_q + CNT_W'(1);
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          ctrl_d     = decode_cmd(cmd_q);
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      cmd_q        <= CMD_NOP;
      ctrl_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cmd_q        <= cmd_d;
      ctrl_q       <= ctrl_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef SEQ_ARB_COUNT_EN
  // Count of acknowledged non-NOP commands, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_count_q <= '0;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

  assign bus.cmd_count = cmd_count_q;
`endif

  assign bus.restart    = ctrl_q.restart;
  assign bus.pause      = ctrl_q.pause;
  assign bus.goto_third = ctrl_q.goto_third;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_id_q;

endmodule

// File: tb/tb_seq_cmd_arbiter.sv
// Scoreboard bench for seq_cmd_arbiter (HOLD_CYCLES=1, PAUSE_CYCLES=2).
// Stimulus pushes expected acks; a negedge monitor checks each ack and
// the control-line activity accumulated since the previous ack.
module tb_seq_cmd_arbiter;
  import seq_arb_pkg::*;

  localparam int unsigned H = 1;
  localparam int unsigned P = 2;

  typedef struct {
    int id;
    int n_restart;
    int n_pause;
    int n_goto;
    int n_busy;
    int gap;
    int count;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  seq_cmd_arbiter_if bus ();

  seq_cmd_arbiter #(.HOLD_CYCLES(H), .PAUSE_CYCLES(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   exp_count = 0;
  int   timeouts  = 0;
  bit   done      = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected response for one granted command
  function automatic exp_t mk(input int id, input cmd_e c, input int gap);
    exp_t e;
    int   hold;
    hold        = (c == CMD_PAUSE) ? P : H;
    e.id        = id;
    e.n_restart = (c == CMD_RESTART || c == CMD_GOTO_THIRD) ? hold : 0;
    e.n_goto    = (c == CMD_GOTO_THIRD) ? hold : 0;
    e.n_pause   = (c == CMD_PAUSE) ? hold : 0;
    e.n_busy    = (c == CMD_NOP) ? 1 : hold + 1;
    e.gap       = gap;
    if (c != CMD_NOP) exp_count = (exp_count + 1) % 256;
    e.count     = exp_count;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset-state checks, ack scoreboard, activity accounting
  int  a_restart = 0, a_pause = 0, a_goto = 0, a_busy = 0;
  int  last_ack_cyc = 0;
  bit  prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_restart",    32'(bus.restart),    0);
      chk("rst_pause",      32'(bus.pause),      0);
      chk("rst_goto_third", 32'(bus.goto_third), 0);
      chk("rst_busy",       32'(bus.busy),       0);
      chk("rst_ack0",       32'(bus.ack0),       0);
      chk("rst_ack1",       32'(bus.ack1),       0);
      chk("rst_grant_id",   32'(bus.grant_id),   0);
`ifdef SEQ_ARB_COUNT_EN
      chk("rst_cmd_count",  32'(bus.cmd_count),  0);
`endif
      a_restart = 0; a_pause = 0; a_goto = 0; a_busy = 0;
      prev_ack  = 1'b0;
    end else begin
      a_restart += int'(bus.restart);
      a_pause   += int'(bus.pause);
      a_goto    += int'(bus.goto_third);
      a_busy    += int'(bus.busy);
      if (bus.ack0 || bus.ack1) begin
        chk("ack_onehot", 32'(bus.ack0 ^ bus.ack1), 1);
        chk("ack_single_cycle", 32'(prev_ack), 0);
        chk("ack_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("ack_id",     32'(bus.ack1),     32'(e.id));
          chk("grant_id",   32'(bus.grant_id), 32'(e.id));
          chk("restart_cycles", 32'(a_restart), 32'(e.n_restart));
          chk("pause_cycles",   32'(a_pause),   32'(e.n_pause));
          chk("goto_cycles",    32'(a_goto),    32'(e.n_goto));
          chk("busy_cycles",    32'(a_busy),    32'(e.n_busy));
          if (e.gap >= 0) chk("grant_spacing", 32'(cyc - last_ack_cyc), 32'(e.gap));
`ifdef SEQ_ARB_COUNT_EN
          chk("cmd_count", 32'(bus.cmd_count), 32'(e.count));
`endif
        end
        last_ack_cyc = cyc;
        a_restart = 0; a_pause = 0; a_goto = 0; a_busy = 0;
      end
      prev_ack = bus.ack0 | bus.ack1;
    end
    if (done) begin
      chk("scoreboard_drained", 32'(q.size()), 0);
      chk("wait_timeouts", 32'(timeouts), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Single requester: hold req until ack is seen, drop at next edge
  task automatic issue(input int id, input cmd_e c);
    bit got;
    got = 1'b0;
    @(negedge clk);
    q.push_back(mk(id, c, -1));
    if (id == 0) begin bus.req0 = 1'b1; bus.cmd0 = c; end
    else         begin bus.req1 = 1'b1; bus.cmd1 = c; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 0 && bus.ack0) || (id == 1 && bus.ack1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeouts++;
    @(posedge clk); #1;
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  // Both requesters hold the same command for n acks
  task automatic tie(input cmd_e c, input int n, input int first, input int gap);
    int seen;
    seen = 0;
    @(negedge clk);
    for (int k = 0; k < n; k++)
      q.push_back(mk((first + k) % 2, c, (k == 0) ? -1 : gap));
    bus.req0 = 1'b1; bus.cmd0 = c;
    bus.req1 = 1'b1; bus.cmd1 = c;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) seen++;
    end
    if (seen < n) timeouts++;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n     = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen_pause;
    bus.req0 = 1'b0; bus.cmd0 = CMD_NOP;
    bus.req1 = 1'b0; bus.cmd1 = CMD_NOP;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(0, CMD_RESTART);
    issue(1, CMD_GOTO_THIRD);
    tie(CMD_PAUSE, 4, 0, P + 2);
    issue(0, CMD_NOP);
    issue(1, CMD_PAUSE);

    // Reset in the middle of a PAUSE drive: no ack may follow
    @(negedge clk);
    bus.req0 = 1'b1; bus.cmd0 = CMD_PAUSE;
    seen_pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pause) begin seen_pause = 1'b1; break; end
    end
    if (!seen_pause) timeouts++;
    do_reset();
    repeat (3) @(negedge clk);

    // last_grant is back to 1, so requester 0 wins the tie
    tie(CMD_RESTART, 2, 0, H + 2);

`ifdef SEQ_ARB_COUNT_EN
    do_reset();
    for (int n = 0; n < 256; n++) issue(0, CMD_RESTART);
`endif

    repeat (4) @(negedge clk);
    done = 1'b1;
  end

  // Absolute guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
